// File: rtl/ifid_queue_pkg.sv
// Shared definitions for the fetch/decode queue: word widths, packed entry type
// and the helper that packs a {pc, instruction} pair.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package ifid_queue_pkg;

    localparam int IFQ_WORD_W  = `WORD;
    localparam int IFQ_INSTR_W = `INSTR_LEN;
    localparam int IFQ_ENTRY_W = `WORD + `INSTR_LEN;

    typedef struct packed {
        logic [IFQ_WORD_W-1:0]  pc;
        logic [IFQ_INSTR_W-1:0] instr;
    } ifq_entry_t;

    function automatic ifq_entry_t ifq_pack(input logic [IFQ_WORD_W-1:0] pc,
                                            input logic [IFQ_INSTR_W-1:0] instr);
        ifq_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/ifid_queue_storage.sv
// DEPTH-entry register array with one write port and an asynchronous read port;
// cleared by reset only.
module ifq_storage
    import ifid_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  ifq_entry_t       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output ifq_entry_t       rd_data
);

    ifq_entry_t mem_r [DEPTH];

    // Entry array: cleared on reset, one entry written per enabled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ifid_queue.sv
// Show-ahead fetch->decode queue with valid/ready handshakes and flush.
// Optional zero-latency empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module ifid_queue
    import ifid_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [`WORD-1:0]      in_pc,
    input  logic [`INSTR_LEN-1:0] in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [`WORD-1:0]      out_pc,
    output logic [`INSTR_LEN-1:0] out_instr,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             in_ready_r, q_valid_r, in_ready_s, q_valid_s;
    logic             push_s, pop_s, bypass_s, wr_en_s;
    ifq_entry_t       head_s;

`ifdef IFQ_BYPASS_EN
    // An empty queue forwards the offered pair directly; flush suppresses it.
    assign bypass_s = ~q_valid_r & in_valid & ~flush;
    assign push_s   = in_valid & in_ready_r & ~(bypass_s & out_ready);
`else
    assign bypass_s = 1'b0;
    assign push_s   = in_valid & in_ready_r;
`endif
    assign pop_s   = q_valid_r & out_ready;
    assign wr_en_s = push_s & ~flush;

    // Next pointer/count/flag state; flush overrides any push or pop.
    always_comb begin
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;
        count_s  = count_r;
        if (flush) begin
            rd_ptr_s = '0;
            wr_ptr_s = '0;
            count_s  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
        in_ready_s = (count_s != CNT_W'(DEPTH));
        q_valid_s  = (count_s != CNT_W'(0));
    end

    // Pointer, occupancy and handshake-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            in_ready_r <= 1'b1;
            q_valid_r  <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
            count_r    <= count_s;
            in_ready_r <= in_ready_s;
            q_valid_r  <= q_valid_s;
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (ifq_pack(in_pc, in_instr)),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    assign in_ready  = in_ready_r;
    assign count     = count_r;
    assign out_valid = q_valid_r | bypass_s;
    assign out_pc    = bypass_s ? in_pc    : head_s.pc;
    assign out_instr = bypass_s ? in_instr : head_s.instr;

endmodule

// File: tb/tb_ifid_queue.sv
// Directed plus random stimulus for ifid_queue, checked against a queue-based
// reference model with immediate assertions.
module tb_ifid_queue;
    import ifid_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  reset, flush, in_valid, out_ready;
    logic                  in_ready, out_valid;
    logic [`WORD-1:0]      in_pc, out_pc;
    logic [`INSTR_LEN-1:0] in_instr, out_instr;
    logic [CNT_W-1:0]      count;

    int checks = 0;
    int errors = 0;
    logic [95:0] mq [$];

    ifid_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check mid-cycle against the model, then
    // advance the model with the FIFO rules after the edge.
    task automatic cycle(input logic iv, input logic [63:0] ipc, input logic [31:0] iins,
                         input logic ordy, input logic fl);
        logic bypass, pop_m, push_m;
        int sz;
        in_valid = iv; in_pc = ipc; in_instr = iins; out_ready = ordy; flush = fl;
        @(negedge clk);
        sz = mq.size();
        bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass = (sz == 0) && iv && !fl;
`endif
        chk("count", 96'(count), 96'(sz));
        chk("in_ready", 96'(in_ready), 96'(sz < DEPTH));
        chk("out_valid", 96'(out_valid), 96'((sz > 0) || bypass));
        if (sz > 0) chk("head", {out_pc, out_instr}, mq[0]);
        else if (bypass) chk("bypass_head", {out_pc, out_instr}, {ipc, iins});
        pop_m  = (sz > 0) && ordy;
        push_m = iv && (sz < DEPTH) && !(bypass && ordy);
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (push_m) mq.push_back({ipc, iins});
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #12;
        chk("rst_count", 96'(count), 96'(0));
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_out_data", {out_pc, out_instr}, 96'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First push, then hold it at the head.
        cycle(1'b1, 64'h0, 32'h8B020020, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Fill to full, attempt a fifth push, then drain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 64'h10, 32'hA000_0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Steady stream through the pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 64'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Three held, flush together with a push, then a lone push.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'(32 + i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 64'h40, 32'hC000_0040, 1'b1, 1'b1);
        cycle(1'b1, 64'h80, 32'hC000_0080, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Empty queue with in_valid and out_ready together (bypass case).
        cycle(1'b1, 64'h100, 32'hD000_0100, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with three entries held.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'(64 + i * 4), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_count", 96'(count), 96'(0));
        chk("async_out_valid", 96'(out_valid), 96'(0));
        chk("async_in_ready", 96'(in_ready), 96'(1));
        chk("async_out_data", {out_pc, out_instr}, 96'(0));
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic including flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
